// File: rtl/breath_mode_ctrl.sv
// ============================================================================
// breath_mode_ctrl : push-button debounce and 5-state mode FSM for breath LED
// Optional long-press-to-OFF feature: BREATH_MODE_LONG_PRESS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module breath_mode_ctrl #(
    parameter logic [19:0] CNT_DEB_MAX  = 20'd9
`ifdef BREATH_MODE_LONG_PRESS_EN
    , parameter logic [23:0] CNT_LONG_MAX = 24'd49
`endif
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_in,
    output logic       key_flag,
    output logic [2:0] mode,
    output logic       breath_en,
    output logic [1:0] speed_sel,
    output logic       led_on,
    output logic       mode_chg
);

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        SLOW = 3'd1,
        MED  = 3'd2,
        FAST = 3'd3,
        ON   = 3'd4
    } mode_t;

    mode_t       state;
    mode_t       state_nxt;
    logic        key_s1;
    logic        key_s2;
    logic [1:0]  sync_fill;
    logic [19:0] cnt_deb;
    logic        armed;
    logic        flag_hit;
    logic        long_hit;
    logic        breath_en_nxt;
    logic [1:0]  speed_sel_nxt;
    logic        led_on_nxt;

    assign mode     = state;
    assign flag_hit = !key_s2 && (cnt_deb == CNT_DEB_MAX - 20'd1) && armed;

`ifdef BREATH_MODE_LONG_PRESS_EN
    logic [23:0] cnt_long;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_long <= 24'd0;
        end else if (key_s2) begin
            cnt_long <= 24'd0;
        end else if ((cnt_deb == CNT_DEB_MAX) && (cnt_long != CNT_LONG_MAX)) begin
            cnt_long <= cnt_long + 24'd1;
        end
    end

    assign long_hit = !key_s2 && (cnt_long == CNT_LONG_MAX);
`else
    assign long_hit = 1'b0;
`endif

    // sync_fill keeps the reset value of key_s2 from arming: only a release
    // actually sampled from key_in may arm the next press.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            sync_fill <= 2'b00;
            cnt_deb   <= 20'd0;
            armed     <= 1'b0;
            key_flag  <= 1'b0;
        end else begin
            key_s1    <= key_in;
            key_s2    <= key_s1;
            sync_fill <= {sync_fill[0], 1'b1};
            key_flag  <= flag_hit;
            if (key_s2) begin
                cnt_deb <= 20'd0;
            end else if (cnt_deb != CNT_DEB_MAX) begin
                cnt_deb <= cnt_deb + 20'd1;
            end
            if (key_s2 && sync_fill[1]) begin
                armed <= 1'b1;
            end else if (flag_hit) begin
                armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= OFF;
            breath_en <= 1'b0;
            speed_sel <= 2'd0;
            led_on    <= 1'b0;
            mode_chg  <= 1'b0;
        end else begin
            state     <= state_nxt;
            breath_en <= breath_en_nxt;
            speed_sel <= speed_sel_nxt;
            led_on    <= led_on_nxt;
            mode_chg  <= (state_nxt != state);
        end
    end

    always_comb begin
        state_nxt     = state;
        breath_en_nxt = 1'b0;
        speed_sel_nxt = 2'd0;
        led_on_nxt    = 1'b0;
        case (state)
            OFF:     if (key_flag) state_nxt = SLOW;
            SLOW:    if (key_flag) state_nxt = MED;
            MED:     if (key_flag) state_nxt = FAST;
            FAST:    if (key_flag) state_nxt = ON;
            ON:      if (key_flag) state_nxt = OFF;
            default: state_nxt = OFF;
        endcase
        if (long_hit) begin
            state_nxt = OFF;
        end
        case (state_nxt)
            SLOW: begin
                breath_en_nxt = 1'b1;
                speed_sel_nxt = 2'd0;
            end
            MED: begin
                breath_en_nxt = 1'b1;
                speed_sel_nxt = 2'd1;
            end
            FAST: begin
                breath_en_nxt = 1'b1;
                speed_sel_nxt = 2'd2;
            end
            ON:      led_on_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire
